// File: rtl/stage_sequencer.sv
// Multi-cycle stage controller: walks FETCH..WRITEBACK, stretches FETCH/DATA
// with bounded wait states, retires instructions and halts on request or timeout.
module stage_sequencer #(
    parameter int MAX_WAIT    = 15,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   fetch_ready,
    input  logic                   is_mem_op,
    input  logic                   data_ready,
    input  logic                   halt_request,
    output logic [4:0]             stage,
    output logic                   fetch_req,
    output logic                   data_req,
    output logic                   retire,
    output logic                   halted,
    output logic                   bus_error,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic [COUNT_WIDTH-1:0] instret_count
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_DATA      = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5
    } state_t;

    // Last permitted stall value of the wait counter; reaching it without a
    // ready is the timeout cycle.
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    state_t                 state_reg, state_next;
    logic [4:0]             stage_reg;
    logic [7:0]             wait_reg, wait_next;
    logic                   timeout_next;
    logic                   halted_reg;
    logic                   bus_error_reg;
    logic [COUNT_WIDTH-1:0] cycle_count_reg;
    logic [COUNT_WIDTH-1:0] instret_count_reg;

    function automatic logic [4:0] stage_onehot(input state_t s);
        logic [4:0] v;
        v = 5'b00000;
        case (s)
            S_FETCH:     v = 5'b00001;
            S_DECODE:    v = 5'b00010;
            S_EXECUTE:   v = 5'b00100;
            S_DATA:      v = 5'b01000;
            S_WRITEBACK: v = 5'b10000;
            default:     v = 5'b00000;
        endcase
        return v;
    endfunction

    always_comb begin
        state_next   = state_reg;
        wait_next    = wait_reg;
        timeout_next = 1'b0;
        case (state_reg)
            S_FETCH: begin
                if (fetch_ready) begin
                    state_next = S_DECODE;
                end else if (wait_reg == WAIT_LIMIT) begin
                    state_next   = S_HALTED;
                    timeout_next = 1'b1;
                end else begin
                    wait_next = wait_reg + 8'd1;
                end
            end
            S_DECODE:  state_next = S_EXECUTE;
            S_EXECUTE: state_next = S_DATA;
            S_DATA: begin
                if (!is_mem_op || data_ready) begin
                    state_next = S_WRITEBACK;
                end else if (wait_reg == WAIT_LIMIT) begin
                    state_next   = S_HALTED;
                    timeout_next = 1'b1;
                end else begin
                    wait_next = wait_reg + 8'd1;
                end
            end
            S_WRITEBACK: state_next = halt_request ? S_HALTED : S_FETCH;
            S_HALTED:    state_next = S_HALTED;
            default:     state_next = S_FETCH;
        endcase
        // Every state entry starts a fresh wait window.
        if (state_next != state_reg) begin
            wait_next = 8'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg         <= S_FETCH;
            stage_reg         <= 5'b00001;
            wait_reg          <= 8'd0;
            halted_reg        <= 1'b0;
            bus_error_reg     <= 1'b0;
            cycle_count_reg   <= '0;
            instret_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            stage_reg     <= stage_onehot(state_next);
            wait_reg      <= wait_next;
            halted_reg    <= halted_reg | (state_next == S_HALTED);
            bus_error_reg <= bus_error_reg | timeout_next;
            // The cycle that moves into HALTED is still counted.
            if (state_reg != S_HALTED) begin
                cycle_count_reg <= cycle_count_reg + COUNT_WIDTH'(1);
            end
            if (state_reg == S_WRITEBACK) begin
                instret_count_reg <= instret_count_reg + COUNT_WIDTH'(1);
            end
        end
    end

    assign stage         = stage_reg;
    assign fetch_req     = (state_reg == S_FETCH);
    assign data_req      = (state_reg == S_DATA) && is_mem_op;
    assign retire        = (state_reg == S_WRITEBACK);
    assign halted        = halted_reg;
    assign bus_error     = bus_error_reg;
    assign cycle_count   = cycle_count_reg;
    assign instret_count = instret_count_reg;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: stage walk, stalls, timeouts, halt and reset.
module tb_stage_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_ready = 1'b0;
    logic        is_mem_op = 1'b0;
    logic        data_ready = 1'b0;
    logic        halt_request = 1'b0;
    logic [4:0]  stage;
    logic        fetch_req, data_req, retire, halted, bus_error;
    logic [31:0] cycle_count, instret_count;

    int compared   = 0;
    int mismatched = 0;

    stage_sequencer #(.MAX_WAIT(15), .COUNT_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .fetch_ready(fetch_ready),
        .is_mem_op(is_mem_op), .data_ready(data_ready), .halt_request(halt_request),
        .stage(stage), .fetch_req(fetch_req), .data_req(data_req), .retire(retire),
        .halted(halted), .bus_error(bus_error), .cycle_count(cycle_count),
        .instret_count(instret_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_stage", 32'(stage), 32'd1);
        chk("rst_fetch_req", 32'(fetch_req), 32'd1);
        chk("rst_data_req", 32'(data_req), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        chk("rst_cycles", cycle_count, 32'd0);
        chk("rst_instret", instret_count, 32'd0);
        $display("txn reset: stage=%0d cycles=%0d", stage, cycle_count);

        // No-stall stream for 20 cycles
        fetch_ready = 1'b1; data_ready = 1'b1; is_mem_op = 1'b0; halt_request = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            chk("walk_stage", 32'(stage), 32'd1 << ((c - 1) % 5));
            chk("walk_retire", 32'(retire), (c % 5 == 0) ? 32'd1 : 32'd0);
            step();
        end
        chk("walk_instret", instret_count, 32'd4);
        chk("walk_cycles", cycle_count, 32'd20);
        $display("txn stream: instret=%0d cycles=%0d", instret_count, cycle_count);

        // Load with 3 stall cycles in DATA
        is_mem_op = 1'b1; data_ready = 1'b0;
        step(); step(); step();
        for (int i = 0; i < 4; i++) begin
            chk("load_stage", 32'(stage), 32'd8);
            chk("load_data_req", 32'(data_req), 32'd1);
            data_ready = (i == 3);
            step();
        end
        chk("load_wb_stage", 32'(stage), 32'd16);
        chk("load_wb_retire", 32'(retire), 32'd1);
        chk("load_wb_data_req", 32'(data_req), 32'd0);
        chk("load_latency", cycle_count, 32'd27);
        is_mem_op = 1'b0;
        step();
        chk("load_instret", instret_count, 32'd5);
        $display("txn load: instret=%0d cycles=%0d", instret_count, cycle_count);

        // Fetch ready arrives on the timeout cycle
        fetch_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            chk("late_fetch_stage", 32'(stage), 32'd1);
            step();
        end
        chk("late_fetch_15th", 32'(stage), 32'd1);
        fetch_ready = 1'b1;
        step();
        chk("late_decode_stage", 32'(stage), 32'd2);
        chk("late_bus_error", 32'(bus_error), 32'd0);
        chk("late_halted", 32'(halted), 32'd0);
        step(); step(); step();
        chk("late_retire", 32'(retire), 32'd1);
        step();
        chk("late_instret", instret_count, 32'd6);
        $display("txn late fetch: stage=%0d bus_error=%0d", stage, bus_error);

        // Fetch timeout
        do_reset();
        fetch_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("fto_stage", 32'(stage), 32'd1);
            chk("fto_halted_early", 32'(halted), 32'd0);
            step();
        end
        chk("fto_stage0", 32'(stage), 32'd0);
        chk("fto_halted", 32'(halted), 32'd1);
        chk("fto_bus_error", 32'(bus_error), 32'd1);
        chk("fto_fetch_req", 32'(fetch_req), 32'd0);
        chk("fto_cycles", cycle_count, 32'd15);
        fetch_ready = 1'b1;
        step(); step(); step();
        chk("fto_cycles_frozen", cycle_count, 32'd15);
        chk("fto_stage_held", 32'(stage), 32'd0);
        $display("txn fetch timeout: halted=%0d bus_error=%0d cycles=%0d", halted, bus_error, cycle_count);

        // Reset out of HALTED
        do_reset();
        chk("rh_stage", 32'(stage), 32'd1);
        chk("rh_cycles", cycle_count, 32'd0);
        chk("rh_instret", instret_count, 32'd0);
        chk("rh_halted", 32'(halted), 32'd0);
        chk("rh_bus_error", 32'(bus_error), 32'd0);
        $display("txn reset from halt: stage=%0d", stage);

        // Halt request on the 2nd WRITEBACK
        data_ready = 1'b1; is_mem_op = 1'b0; halt_request = 1'b0;
        step(); step(); step(); step();
        chk("hr_wb1_retire", 32'(retire), 32'd1);
        step();
        halt_request = 1'b1;
        chk("hr_fetch2", 32'(stage), 32'd1);
        step(); step(); step(); step();
        chk("hr_wb2_stage", 32'(stage), 32'd16);
        step();
        chk("hr_instret", instret_count, 32'd2);
        chk("hr_halted", 32'(halted), 32'd1);
        chk("hr_bus_error", 32'(bus_error), 32'd0);
        chk("hr_cycles", cycle_count, 32'd10);
        is_mem_op = 1'b1; halt_request = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hr_q_stage", 32'(stage), 32'd0);
            chk("hr_q_reqs", {29'd0, fetch_req, data_req, retire}, 32'd0);
        end
        chk("hr_q_instret", instret_count, 32'd2);
        chk("hr_q_cycles", cycle_count, 32'd10);
        $display("txn halt request: instret=%0d cycles=%0d", instret_count, cycle_count);

        // DATA timeout with is_mem_op held high
        do_reset();
        data_ready = 1'b0;
        step(); step(); step();
        for (int i = 0; i < 15; i++) begin
            chk("dto_stage", 32'(stage), 32'd8);
            step();
        end
        chk("dto_halted", 32'(halted), 32'd1);
        chk("dto_bus_error", 32'(bus_error), 32'd1);
        chk("dto_instret", instret_count, 32'd0);
        chk("dto_cycles", cycle_count, 32'd18);
        $display("txn data timeout: bus_error=%0d cycles=%0d", bus_error, cycle_count);

        // Reset during a DATA stall
        do_reset();
        step(); step(); step();
        step(); step();
        chk("rd_in_data", 32'(stage), 32'd8);
        do_reset();
        chk("rd_stage", 32'(stage), 32'd1);
        chk("rd_cycles", cycle_count, 32'd0);
        chk("rd_instret", instret_count, 32'd0);
        chk("rd_retire", 32'(retire), 32'd0);
        chk("rd_data_req", 32'(data_req), 32'd0);
        chk("rd_halted", 32'(halted), 32'd0);
        $display("txn reset in data stall: stage=%0d", stage);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
